// File: rtl/multi_cycle_control.sv
// Multicycle controller for the MIPS-subset CPU: steps each instruction through IF/ID/EXE/MEM/WB
// and drives all datapath enables and selects combinationally from the current state and IR fields.
module multi_cycle_control (
    input  logic       CLK,
    input  logic       Reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       sign,
    output logic [2:0] state,
    output logic       PCWre,
    output logic [1:0] PCSrc,
    output logic       IRWre,
    output logic       RegWre,
    output logic [1:0] RegDst,
    output logic       WrRegDSrc,
    output logic       ALUSrcA,
    output logic       ALUSrcB,
    output logic       ExtSel,
    output logic [2:0] ALUOp,
    output logic       mRD,
    output logic       mWR,
    output logic       DBDataSrc
);

    typedef enum logic [2:0] {
        S_IF   = 3'b000,
        S_ID   = 3'b001,
        S_EXE  = 3'b010,
        S_MEM  = 3'b011,
        S_WB   = 3'b100,
        S_HALT = 3'b111
    } state_t;

    state_t state_q, state_d;

    logic is_rtype;
    logic r_add, r_sub, r_and, r_or, r_slt, r_sll, r_jr, r_alu;
    logic i_addiu, i_andi, i_ori, i_slti, i_lw, i_sw;
    logic i_beq, i_bne, i_bgtz, i_j, i_jal, i_halt;
    logic imm_alu, is_branch, known, br_taken;
    logic       alu_a, alu_b, ext;
    logic [2:0] alu_op;

    assign is_rtype = (op == 6'b000000);
    assign r_add    = is_rtype && (funct == 6'b100000);
    assign r_sub    = is_rtype && (funct == 6'b100010);
    assign r_and    = is_rtype && (funct == 6'b100100);
    assign r_or     = is_rtype && (funct == 6'b100101);
    assign r_slt    = is_rtype && (funct == 6'b101010);
    assign r_sll    = is_rtype && (funct == 6'b000000);
    assign r_jr     = is_rtype && (funct == 6'b001000);
    assign r_alu    = r_add | r_sub | r_and | r_or | r_slt | r_sll;

    assign i_addiu = (op == 6'b001001);
    assign i_andi  = (op == 6'b001100);
    assign i_ori   = (op == 6'b001101);
    assign i_slti  = (op == 6'b001010);
    assign i_lw    = (op == 6'b100011);
    assign i_sw    = (op == 6'b101011);
    assign i_beq   = (op == 6'b000100);
    assign i_bne   = (op == 6'b000101);
    assign i_bgtz  = (op == 6'b000111);
    assign i_j     = (op == 6'b000010);
    assign i_jal   = (op == 6'b000011);
    assign i_halt  = (op == 6'b111111);

    assign imm_alu   = i_addiu | i_andi | i_ori | i_slti;
    assign is_branch = i_beq | i_bne | i_bgtz;
    assign known     = r_alu | r_jr | imm_alu | i_lw | i_sw | is_branch | i_j | i_jal | i_halt;
    // bgtz compares rs against $0, so rs > 0 means a nonzero, non-negative difference
    assign br_taken  = (i_beq & zero) | (i_bne & ~zero) | (i_bgtz & ~zero & ~sign);

    // ALU setup for the current instruction; only driven out in EXE/MEM/WB
    always_comb begin
        alu_a  = r_sll;
        alu_b  = imm_alu | i_lw | i_sw;
        ext    = ~(i_andi | i_ori);
        alu_op = 3'b000;
        if (is_branch || r_sub)  alu_op = 3'b001;
        else if (i_andi || r_and) alu_op = 3'b010;
        else if (i_ori || r_or)   alu_op = 3'b011;
        else if (i_slti || r_slt) alu_op = 3'b100;
        else if (r_sll)           alu_op = 3'b101;
    end

    always_ff @(posedge CLK) begin
        if (Reset) state_q <= S_IF;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d   = S_IF;
        PCWre     = 1'b0;
        PCSrc     = 2'b00;
        IRWre     = 1'b0;
        RegWre    = 1'b0;
        RegDst    = 2'b00;
        WrRegDSrc = 1'b0;
        ALUSrcA   = 1'b0;
        ALUSrcB   = 1'b0;
        ExtSel    = 1'b0;
        ALUOp     = 3'b000;
        mRD       = 1'b0;
        mWR       = 1'b0;
        DBDataSrc = 1'b0;

        if (state_q == S_EXE || state_q == S_MEM || state_q == S_WB) begin
            ALUSrcA = alu_a;
            ALUSrcB = alu_b;
            ExtSel  = ext;
            ALUOp   = alu_op;
        end

        case (state_q)
            S_IF: begin
                IRWre   = 1'b1;
                state_d = S_ID;
            end
            S_ID: begin
                if (i_halt) begin
                    state_d = S_HALT;
                end else if (i_j || i_jal || r_jr || !known) begin
                    // jumps and unknown opcodes retire here; unknown ones just advance to PC+4
                    PCWre = 1'b1;
                    if (i_j || i_jal) PCSrc = 2'b11;
                    else if (r_jr)    PCSrc = 2'b10;
                    if (i_jal) begin
                        RegWre = 1'b1;
                        RegDst = 2'b10;
                    end
                    state_d = S_IF;
                end else begin
                    state_d = S_EXE;
                end
            end
            S_EXE: begin
                if (is_branch) begin
                    PCWre   = 1'b1;
                    PCSrc   = br_taken ? 2'b01 : 2'b00;
                    state_d = S_IF;
                end else if (i_lw || i_sw) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                if (i_lw) begin
                    mRD     = 1'b1;
                    state_d = S_WB;
                end else if (i_sw) begin
                    mWR   = 1'b1;
                    PCWre = 1'b1;
                end
            end
            S_WB: begin
                RegWre    = 1'b1;
                WrRegDSrc = 1'b1;
                RegDst    = is_rtype ? 2'b01 : 2'b00;
                DBDataSrc = i_lw;
                PCWre     = 1'b1;
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_IF;
        endcase

        // a reset cycle must not commit any architectural write
        if (Reset) begin
            PCWre  = 1'b0;
            IRWre  = 1'b0;
            RegWre = 1'b0;
            mRD    = 1'b0;
            mWR    = 1'b0;
            PCSrc  = 2'b00;
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_multi_cycle_control.sv
// Bench for multi_cycle_control: each instruction is modelled as a path of states with the
// controls expected at each step, compared cycle by cycle against the controller.
module tb_multi_cycle_control;

    logic       CLK = 1'b0;
    logic       Reset = 1'b1;
    logic [5:0] op = 6'b0;
    logic [5:0] funct = 6'b0;
    logic       zero = 1'b0;
    logic       sign = 1'b0;
    logic [2:0] state;
    logic       PCWre, IRWre, RegWre, WrRegDSrc, ALUSrcA, ALUSrcB, ExtSel, mRD, mWR, DBDataSrc;
    logic [1:0] PCSrc, RegDst;
    logic [2:0] ALUOp;

    int tests = 0;
    int failures = 0;

    localparam int K_UND = 0, K_J = 1, K_JAL = 2, K_JR = 3, K_HALT = 4;
    localparam int K_BR = 5, K_R = 6, K_I = 7, K_LW = 8, K_SW = 9;

    multi_cycle_control dut (
        .CLK(CLK), .Reset(Reset), .op(op), .funct(funct), .zero(zero), .sign(sign),
        .state(state), .PCWre(PCWre), .PCSrc(PCSrc), .IRWre(IRWre), .RegWre(RegWre),
        .RegDst(RegDst), .WrRegDSrc(WrRegDSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ExtSel(ExtSel), .ALUOp(ALUOp), .mRD(mRD), .mWR(mWR), .DBDataSrc(DBDataSrc)
    );

    always #5 CLK = ~CLK;

    function automatic int classify(input logic [5:0] o, input logic [5:0] f);
        if (o == 6'b000000) begin
            case (f)
                6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b000000: return K_R;
                6'b001000: return K_JR;
                default:   return K_UND;
            endcase
        end
        case (o)
            6'b001001, 6'b001100, 6'b001101, 6'b001010: return K_I;
            6'b100011: return K_LW;
            6'b101011: return K_SW;
            6'b000100, 6'b000101, 6'b000111: return K_BR;
            6'b000010: return K_J;
            6'b000011: return K_JAL;
            6'b111111: return K_HALT;
            default:   return K_UND;
        endcase
    endfunction

    // cycles from IF back to IF
    function automatic int cpi(input int kind);
        case (kind)
            K_BR:           return 3;
            K_R, K_I, K_SW: return 4;
            K_LW:           return 5;
            default:        return 2;
        endcase
    endfunction

    function automatic logic [2:0] exp_state(input int kind, input int k);
        if (k < 2)          return 3'(k);
        if (kind == K_HALT) return 3'b111;
        if (k == 2)         return 3'b010;
        if ((kind == K_LW || kind == K_SW) && k == 3) return 3'b011;
        return 3'b100;
    endfunction

    // {ALUSrcA, ALUSrcB, ExtSel, ALUOp}
    function automatic logic [5:0] exp_alu(input int kind, input logic [5:0] o, input logic [5:0] f);
        if (kind == K_BR) return 6'b001_001;
        if (kind == K_LW || kind == K_SW) return 6'b011_000;
        if (kind == K_I) begin
            case (o)
                6'b001100: return 6'b010_010;
                6'b001101: return 6'b010_011;
                6'b001010: return 6'b011_100;
                default:   return 6'b011_000;
            endcase
        end
        case (f)
            6'b100010: return 6'b001_001;
            6'b100100: return 6'b001_010;
            6'b100101: return 6'b001_011;
            6'b101010: return 6'b001_100;
            6'b000000: return 6'b101_101;
            default:   return 6'b001_000;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge CLK);
            Reset = 1'b1;
            {zero, sign} = 2'($urandom_range(0, 3));
            #1;
            check("reset_forced_zero", 32'({PCWre, IRWre, RegWre, mRD, mWR, PCSrc}), 32'd0);
        end
    endtask

    // zs < 0: random zero/sign each cycle; abort_k >= 0: assert Reset in that cycle
    task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input int zs,
                             input int abort_k, input int hold);
        int kind, len;
        logic [2:0] st;
        logic last, taken, wb, jal_id;
        logic [1:0] pcsrc, rdst;
        logic [5:0] alu;
        logic [16:0] expb;
        kind = classify(o, f);
        len  = (kind == K_HALT) ? 2 + hold : cpi(kind);
        for (int k = 0; k < len; k++) begin
            @(negedge CLK);
            op = o;
            funct = f;
            if (zs < 0) {zero, sign} = 2'($urandom_range(0, 3));
            else        {zero, sign} = 2'(zs);
            Reset = (k == abort_k);
            #1;
            st = exp_state(kind, k);
            check($sformatf("state op=%b f=%b k=%0d", o, f, k), 32'(state), 32'(st));
            if (k == abort_k) begin
                check("abort_forced_zero", 32'({PCWre, IRWre, RegWre, mRD, mWR, PCSrc}), 32'd0);
                return;
            end
            last   = (k == len - 1) && (kind != K_HALT);
            wb     = (st == 3'b100);
            jal_id = (kind == K_JAL) && (k == 1);
            taken  = (o == 6'b000100 && zero) || (o == 6'b000101 && !zero) ||
                     (o == 6'b000111 && !zero && !sign);
            pcsrc = 2'b00;
            if (last) begin
                if (kind == K_J || kind == K_JAL) pcsrc = 2'b11;
                else if (kind == K_JR)            pcsrc = 2'b10;
                else if (kind == K_BR && taken)   pcsrc = 2'b01;
            end
            rdst = jal_id ? 2'b10 : ((wb && kind == K_R) ? 2'b01 : 2'b00);
            alu  = (st == 3'b010 || st == 3'b011 || st == 3'b100) ? exp_alu(kind, o, f) : 6'b0;
            expb = {last, pcsrc, (k == 0), (jal_id || wb), rdst, wb, alu,
                    (kind == K_LW && st == 3'b011), (kind == K_SW && st == 3'b011),
                    (kind == K_LW && wb)};
            check($sformatf("ctrl op=%b f=%b k=%0d zs=%b", o, f, k, {zero, sign}),
                  32'({PCWre, PCSrc, IRWre, RegWre, RegDst, WrRegDSrc, ALUSrcA, ALUSrcB,
                       ExtSel, ALUOp, mRD, mWR, DBDataSrc}), 32'(expb));
        end
    endtask

    logic [5:0] ops [12];
    logic [5:0] rfs [7];

    initial begin
        int r, kind, ab;
        logic [5:0] o, f;
        ops = '{6'b001001, 6'b001100, 6'b001101, 6'b001010, 6'b100011, 6'b101011,
                6'b000100, 6'b000101, 6'b000111, 6'b000010, 6'b000011, 6'b000000};
        rfs = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b000000, 6'b001000};

        do_reset(2);
        run_instr(6'b001001, 6'b000000, -1, -1, 0);          // addiu
        run_instr(6'b000100, 6'b000000, 2, -1, 0);           // beq zero=1
        run_instr(6'b000100, 6'b000000, 0, -1, 0);           // beq zero=0
        run_instr(6'b000101, 6'b000000, 0, -1, 0);           // bne taken
        run_instr(6'b000101, 6'b000000, 2, -1, 0);           // bne not taken
        run_instr(6'b000111, 6'b000000, 0, -1, 0);           // bgtz {zero,sign}=00
        run_instr(6'b000111, 6'b000000, 1, -1, 0);           // bgtz 01
        run_instr(6'b000111, 6'b000000, 2, -1, 0);           // bgtz 10
        run_instr(6'b000011, 6'b000000, -1, -1, 0);          // jal
        run_instr(6'b000000, 6'b001000, -1, -1, 0);          // jr
        run_instr(6'b100011, 6'b000000, -1, -1, 0);          // lw
        run_instr(6'b101011, 6'b000000, -1, -1, 0);          // sw
        run_instr(6'b010000, 6'b000000, -1, -1, 0);          // undefined op
        run_instr(6'b111111, 6'b000000, -1, -1, 10);         // halt, hold 10 cycles
        do_reset(1);
        run_instr(6'b000000, 6'b100000, -1, 3, 0);           // add, reset in WB
        run_instr(6'b000000, 6'b000000, -1, -1, 0);          // sll

        for (int n = 0; n < 300; n++) begin
            r = $urandom_range(0, 15);
            f = rfs[$urandom_range(0, 6)];
            if (r < 12)       o = ops[r];
            else if (r < 14)  begin o = 6'b000000; f = 6'($urandom); end
            else if (r == 14) o = 6'b111111;
            else              o = 6'($urandom);
            kind = classify(o, f);
            ab = -1;
            if (kind != K_HALT && $urandom_range(0, 9) == 0) ab = $urandom_range(0, cpi(kind) - 1);
            run_instr(o, f, -1, ab, 3);
            if (kind == K_HALT) do_reset(1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
